// File: rtl/divider_pkg.sv
// Shared definitions for the 8-bit sequential restoring divider.
package divider_pkg;

    localparam int unsigned DIV_W    = 8;
    localparam int unsigned DIV_ITER = 8;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_9bits.sv
// Combinational 9-bit subtractor: ripple of full adders on a + ~b + 1.
module sub_9bits (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] diff,
    output logic       borrow
);

    logic [9:0] carry;

    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        diff     = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            diff[i]    = a[i] ^ ~b[i] ^ carry[i];
            carry[i+1] = (a[i] & ~b[i]) | (a[i] & carry[i]) | (~b[i] & carry[i]);
        end
        // No carry out of the top stage means a < b.
        borrow = ~carry[9];
    end

endmodule

// File: rtl/divider_8bits.sv
// 8-bit unsigned restoring divider, one trial subtraction per cycle,
// with start/busy handshake and a one-cycle done pulse.
module divider_8bits
    import divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    logic [DIV_W-1:0] q;
    logic [DIV_W-1:0] d;
    // R[8] is always zero after a step, so only the low 8 bits are stored.
    logic [DIV_W-1:0] r;
    logic [2:0]       cnt;
    logic             dz;
    logic [DIV_W:0]   diff;
    logic             borrow;
    logic             accept;

    sub_9bits u_sub (
        .a      ({r, q[DIV_W-1]}),
        .b      ({1'b0, d}),
        .diff   (diff),
        .borrow (borrow)
    );

    // The pulse and result registers trail DONE by one edge; busy covers the pulse.
    assign busy   = (state != IDLE) || done;
    assign accept = (state == IDLE) && !done && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q           <= '0;
            d           <= '0;
            r           <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        d   <= divisor;
                        cnt <= '0;
                        if (divisor == '0) begin
                            q     <= DIV_ZERO_Q;
                            r     <= dividend;
                            dz    <= 1'b1;
                            state <= DONE;
                        end else begin
                            q     <= dividend;
                            r     <= '0;
                            dz    <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!borrow) begin
                        r <= diff[DIV_W-1:0];
                        q <= {q[DIV_W-2:0], 1'b1};
                    end else begin
                        r <= {r[DIV_W-2:0], q[DIV_W-1]};
                        q <= {q[DIV_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(DIV_ITER - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    quotient    <= q;
                    remainder   <= r;
                    div_by_zero <= dz;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
